// File: rtl/draw_rect.sv
// Rectangle overlay: composites a solid rectangle over the incoming pixel stream.
// Latency: 2 pclk cycles, identical for colour and timing outputs.
// Backpressure: none; free-running pixel stream, one pixel accepted every cycle.
//
// Ports:
//   pclk, rst              pixel clock, asynchronous active-low reset
//   hcount_in..vblnk_in    timing from the upstream timing stage
//   rgb_in                 background colour (4:4:4)
//   xpos, ypos             rectangle top-left corner, sampled once per frame
//   hcount_out..vblnk_out  timing delayed by 2 cycles to line up with rgb_out
//   rgb_out                composited colour
// Optional feature: define DRAW_RECT_BORDER_EN to paint the rectangle outline
// in BORDER_COLOR.
module draw_rect #(
  parameter int          RECT_WIDTH   = 48,
  parameter int          RECT_HEIGHT  = 64,
  parameter logic [11:0] RECT_COLOR   = 12'hF80,
  parameter logic [11:0] BORDER_COLOR = 12'h000
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic [10:0] hcount_in,
  input  logic [10:0] vcount_in,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        hblnk_in,
  input  logic        vblnk_in,
  input  logic [11:0] rgb_in,
  input  logic [11:0] xpos,
  input  logic [11:0] ypos,
  output logic [10:0] hcount_out,
  output logic [10:0] vcount_out,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        hblnk_out,
  output logic        vblnk_out,
  output logic [11:0] rgb_out
);

  localparam logic [12:0] W13 = 13'(RECT_WIDTH);
  localparam logic [12:0] H13 = 13'(RECT_HEIGHT);

  // Frame-latched position and vblank edge detector
  logic [11:0] x_lat;
  logic [11:0] y_lat;
  logic        vblnk_prev;
  logic        vblnk_rise;

  assign vblnk_rise = vblnk_in & ~vblnk_prev;

  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      x_lat      <= '0;
      y_lat      <= '0;
      vblnk_prev <= 1'b0;
    end else begin
      vblnk_prev <= vblnk_in;
      // Position only moves at the start of vertical blanking so a frame
      // never shows the rectangle at two places.
      if (vblnk_rise) begin
        x_lat <= xpos;
        y_lat <= ypos;
      end
    end
  end

  // Hit test in 13 bits so rectangles near the 12-bit limit do not wrap.
  logic [12:0] hc13, vc13, x_lo, y_lo, x_end, y_end;
  logic        in_rect_c;

  assign hc13  = {2'b00, hcount_in};
  assign vc13  = {2'b00, vcount_in};
  assign x_lo  = {1'b0, x_lat};
  assign y_lo  = {1'b0, y_lat};
  assign x_end = x_lo + W13;
  assign y_end = y_lo + H13;

  assign in_rect_c = (hc13 >= x_lo) && (hc13 < x_end) &&
                     (vc13 >= y_lo) && (vc13 < y_end);

`ifdef DRAW_RECT_BORDER_EN
  logic border_c;
  logic border_s1;

  assign border_c = (hc13 == x_lo) || (hc13 == x_end - 13'd1) ||
                    (vc13 == y_lo) || (vc13 == y_end - 13'd1);
`endif

  // Stage 1: timing, background colour and hit flag
  logic [10:0] hcount_s1, vcount_s1;
  logic        hsync_s1, vsync_s1, hblnk_s1, vblnk_s1;
  logic [11:0] rgb_s1;
  logic        in_rect_s1;

  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      hcount_s1  <= '0;
      vcount_s1  <= '0;
      hsync_s1   <= 1'b0;
      vsync_s1   <= 1'b0;
      hblnk_s1   <= 1'b0;
      vblnk_s1   <= 1'b0;
      rgb_s1     <= '0;
      in_rect_s1 <= 1'b0;
    end else begin
      hcount_s1  <= hcount_in;
      vcount_s1  <= vcount_in;
      hsync_s1   <= hsync_in;
      vsync_s1   <= vsync_in;
      hblnk_s1   <= hblnk_in;
      vblnk_s1   <= vblnk_in;
      rgb_s1     <= rgb_in;
      in_rect_s1 <= in_rect_c;
    end
  end

`ifdef DRAW_RECT_BORDER_EN
  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) border_s1 <= 1'b0;
    else      border_s1 <= border_c;
  end
`endif

  // Stage 2: colour select; blanking always forces black
  logic [11:0] rect_pix;
  logic [11:0] rgb_nxt;

`ifdef DRAW_RECT_BORDER_EN
  assign rect_pix = border_s1 ? BORDER_COLOR : RECT_COLOR;
`else
  assign rect_pix = RECT_COLOR;
`endif

  always_comb begin
    rgb_nxt = rgb_s1;
    if (hblnk_s1 || vblnk_s1) rgb_nxt = 12'h000;
    else if (in_rect_s1)      rgb_nxt = rect_pix;
  end

  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      hcount_out <= '0;
      vcount_out <= '0;
      hsync_out  <= 1'b0;
      vsync_out  <= 1'b0;
      hblnk_out  <= 1'b0;
      vblnk_out  <= 1'b0;
      rgb_out    <= '0;
    end else begin
      hcount_out <= hcount_s1;
      vcount_out <= vcount_s1;
      hsync_out  <= hsync_s1;
      vsync_out  <= vsync_s1;
      hblnk_out  <= hblnk_s1;
      vblnk_out  <= vblnk_s1;
      rgb_out    <= rgb_nxt;
    end
  end

endmodule
